button_debouncer: RTL

Input-side conditioning block for the iCEBreaker user buttons: takes the raw, asynchronous button pins, synchronizes them into the `CLK` domain and debounces them. It produces clean per-button levels plus single-cycle press and release pulses. It sits between the top-level button pins and any counter/LED logic that consumes button state, replacing direct use of raw pins in arithmetic.

---
 rtl/button_debouncer_if.sv | 28 ++
 rtl/button_debouncer.sv | 78 +++++++
 2 files changed

// File: rtl/button_debouncer_if.sv
// button_debouncer_if: button pin/state bundle between the raw pins and the debouncer.
//   BTN_RAW     raw active-high button pins (driven by the pin side)
//   BTN_LEVEL   debounced pressed state per button
//   BTN_PRESS   one-cycle pulse on debounced press (and auto-repeat when built)
//   BTN_RELEASE one-cycle pulse on debounced release
//   modport master: pin/consumer side; modport slave: debouncer side
interface button_debouncer_if #(
    parameter int BUTTONS = 4
);
    logic [BUTTONS-1:0] BTN_RAW;
    logic [BUTTONS-1:0] BTN_LEVEL;
    logic [BUTTONS-1:0] BTN_PRESS;
    logic [BUTTONS-1:0] BTN_RELEASE;

    modport master (
        output BTN_RAW,
        input  BTN_LEVEL,
        input  BTN_PRESS,
        input  BTN_RELEASE
    );

    modport slave (
        input  BTN_RAW,
        output BTN_LEVEL,
        output BTN_PRESS,
        output BTN_RELEASE
    );
endinterface

// File: rtl/button_debouncer.sv
// button_debouncer: two-flop synchronizer plus per-channel debounce with press/release pulses.
//   CLK  rising-edge clock
//   RST  asynchronous active-high reset, clears all state and outputs
//   btn  button_debouncer_if.slave: BTN_RAW in; BTN_LEVEL, BTN_PRESS, BTN_RELEASE out
//   Optional macro BTN_REPEAT_EN builds a per-channel hold counter that re-fires
//   BTN_PRESS 2^(REPEAT_LOG2+1) cycles after a press, then every 2^REPEAT_LOG2 cycles.
module button_debouncer #(
    parameter int BUTTONS     = 4,
    parameter int STABLE_LOG2 = 16,
    parameter int REPEAT_LOG2 = 21
) (
    input logic               CLK,
    input logic               RST,
    button_debouncer_if.slave btn
);
    logic [BUTTONS-1:0] level_w;
    logic [BUTTONS-1:0] press_w;
    logic [BUTTONS-1:0] release_w;

    for (genvar i = 0; i < BUTTONS; i++) begin : g_ch
        logic                   sync1_q, sync2_q;
        logic [STABLE_LOG2-1:0] cnt_q, cnt_d;
        logic                   level_q, level_d;
        logic                   press_q, press_d;
        logic                   release_q, release_d;
        logic                   disagree, flip, rep;

        assign disagree = sync2_q ^ level_q;
        // the 2^STABLE_LOG2-th consecutive disagreeing sample flips the level
        assign flip      = disagree & (&cnt_q);
        assign cnt_d     = (disagree & ~flip) ? cnt_q + 1'b1 : '0;
        assign level_d   = level_q ^ flip;
        assign press_d   = (flip & ~level_q) | rep;
        assign release_d = flip & level_q;

`ifdef BTN_REPEAT_EN
        logic [REPEAT_LOG2:0] hold_q, hold_d;
        // all-ones marks a repeat; reloading with 2^REPEAT_LOG2 gives the shorter period after the first
        assign rep    = level_q & ~flip & (&hold_q);
        assign hold_d = (~level_q | flip) ? '0 :
                        rep               ? {1'b1, {REPEAT_LOG2{1'b0}}} :
                                            hold_q + 1'b1;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) hold_q <= '0;
            else     hold_q <= hold_d;
        end
`else
        assign rep = 1'b0;
`endif

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                sync1_q   <= 1'b0;
                sync2_q   <= 1'b0;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                sync1_q   <= btn.BTN_RAW[i];
                sync2_q   <= sync1_q;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        assign level_w[i]   = level_q;
        assign press_w[i]   = press_q;
        assign release_w[i] = release_q;
    end

    assign btn.BTN_LEVEL   = level_w;
    assign btn.BTN_PRESS   = press_w;
    assign btn.BTN_RELEASE = release_w;
endmodule
